// File: rtl/ltpi_pkg.sv
// rtl/ltpi_pkg.sv - shared LTPI link types, timer constants and PLL sequencer state encoding
package ltpi_pkg;

  // Link speed multipliers relative to the base LTPI link rate
  typedef enum logic [3:0] {
    LINK_SPEED_1X  = 4'd0,
    LINK_SPEED_2X  = 4'd1,
    LINK_SPEED_3X  = 4'd2,
    LINK_SPEED_4X  = 4'd3,
    LINK_SPEED_6X  = 4'd4,
    LINK_SPEED_8X  = 4'd5,
    LINK_SPEED_10X = 4'd6,
    LINK_SPEED_12X = 4'd7,
    LINK_SPEED_16X = 4'd8
  } link_speed_t;

  // Speed used for training and for recovery after link loss or PLL failure
  localparam link_speed_t LINK_SPEED_BASE = LINK_SPEED_1X;

  // 1 ms expressed in 60 MHz management clock cycles
  localparam int TIMER_1MS_60MHZ = 60000;

  // Widths of the PLL sequencer timers
  localparam int PLL_LOCK_TIMER_W   = 17;
  localparam int PLL_SETTLE_TIMER_W = 8;

  // PLL reconfiguration sequencer states, visible through CSR
  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_RESET    = 3'd1,
    SEQ_CFG      = 3'd2,
    SEQ_LOCK     = 3'd3,
    SEQ_SETTLE   = 3'd4,
    SEQ_DONE     = 3'd5,
    SEQ_WAIT_LOW = 3'd6
  } pll_seq_state_t;

  // True when the given speed is something other than the base rate
  function automatic logic is_operational_speed(input link_speed_t speed);
    return speed != LINK_SPEED_BASE;
  endfunction

endpackage

// File: rtl/mgmt_phy_pll_timer.sv
// rtl/mgmt_phy_pll_timer.sv - loadable saturating up-counter for the PLL sequencer
module mgmt_phy_pll_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  // Load wins over increment; the count sticks at all-ones instead of wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc && (count != COUNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mgmt_phy_pll_sequencer.sv
// rtl/mgmt_phy_pll_sequencer.sv - PLL reconfiguration sequencer for the LTPI management PHY
module mgmt_phy_pll_sequencer
  import ltpi_pkg::*;
#(
  parameter int RESET_HOLD_CYC   = 16,
  parameter int LOCK_TIMEOUT_CYC = TIMER_1MS_60MHZ,
  parameter int SETTLE_CYC       = 64,
  parameter int MAX_RETRY        = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           pll_reconfig,
  input  link_speed_t    operational_speed,
  input  logic           pll_locked,
  input  logic           cfg_ack,
  output logic           cfg_req,
  output link_speed_t    cfg_speed,
  output logic           pll_areset,
  output logic           pll_configuration_done,
  output logic           change_freq_st,
  output logic           pll_error,
  output logic [1:0]     retry_cnt,
  output pll_seq_state_t seq_state
);

  localparam logic [PLL_LOCK_TIMER_W-1:0]   RESET_LAST  = PLL_LOCK_TIMER_W'(RESET_HOLD_CYC - 1);
  localparam logic [PLL_LOCK_TIMER_W-1:0]   LOCK_LAST   = PLL_LOCK_TIMER_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [PLL_SETTLE_TIMER_W-1:0] SETTLE_LAST = PLL_SETTLE_TIMER_W'(SETTLE_CYC - 1);
  localparam logic [2:0]                    RETRY_LIMIT = 3'(MAX_RETRY);

  pll_seq_state_t                state, state_nxt;
  link_speed_t                   target_nxt;
  logic                          cfg_req_nxt;
  logic                          areset_nxt;
  logic                          done_nxt;
  logic                          chg_nxt;
  logic                          err_nxt;
  logic [1:0]                    retry_nxt;
  logic [2:0]                    retry_sum;
  // Set once a configuration completes; cleared by reset and by exhausted retries
  logic                          speed_change;
  logic                          speed_change_nxt;

  logic                          lock_load, lock_inc;
  logic                          settle_load, settle_inc;
  logic [PLL_LOCK_TIMER_W-1:0]   lock_cnt;
  logic [PLL_SETTLE_TIMER_W-1:0] settle_cnt;

  assign seq_state = state;

  // Lock timer also measures the reset hold, since both phases never overlap
  mgmt_phy_pll_timer #(.WIDTH(PLL_LOCK_TIMER_W)) u_lock_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (lock_load),
    .load_value ('0),
    .inc        (lock_inc),
    .count      (lock_cnt)
  );

  mgmt_phy_pll_timer #(.WIDTH(PLL_SETTLE_TIMER_W)) u_settle_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (settle_load),
    .load_value ('0),
    .inc        (settle_inc),
    .count      (settle_cnt)
  );

  // Next state and next values of every registered output
  always_comb begin
    state_nxt        = state;
    target_nxt       = cfg_speed;
    cfg_req_nxt      = 1'b0;
    areset_nxt       = pll_areset;
    done_nxt         = 1'b0;
    chg_nxt          = change_freq_st;
    err_nxt          = pll_error;
    retry_nxt        = retry_cnt;
    speed_change_nxt = speed_change;
    lock_load        = 1'b0;
    lock_inc         = 1'b0;
    settle_load      = 1'b0;
    settle_inc       = 1'b0;
    retry_sum        = {1'b0, retry_cnt} + 3'd1;

    case (state)
      SEQ_IDLE: begin
        areset_nxt = 1'b0;
        if (pll_reconfig) begin
          // Only step up to operational speed from a known-good base configuration
          target_nxt = (!change_freq_st && speed_change) ? operational_speed : LINK_SPEED_BASE;
          areset_nxt = 1'b1;
          lock_load  = 1'b1;
          state_nxt  = SEQ_RESET;
        end
      end

      SEQ_RESET: begin
        areset_nxt = 1'b1;
        if (lock_cnt >= RESET_LAST) begin
          cfg_req_nxt = 1'b1;
          state_nxt   = SEQ_CFG;
        end else begin
          lock_inc = 1'b1;
        end
      end

      SEQ_CFG: begin
        areset_nxt = 1'b1;
        if (cfg_ack) begin
          areset_nxt = 1'b0;
          lock_load  = 1'b1;
          state_nxt  = SEQ_LOCK;
        end else begin
          cfg_req_nxt = 1'b1;
        end
      end

      SEQ_LOCK: begin
        lock_inc = 1'b1;
        if (pll_locked) begin
          settle_load = 1'b1;
          state_nxt   = SEQ_SETTLE;
        end else if (lock_cnt >= LOCK_LAST) begin
          if (retry_sum < RETRY_LIMIT) begin
            retry_nxt  = retry_sum[1:0];
            areset_nxt = 1'b1;
            lock_load  = 1'b1;
            state_nxt  = SEQ_RESET;
          end else begin
            // Give up: flag it and make any still-pending request start over at base
            err_nxt          = 1'b1;
            target_nxt       = LINK_SPEED_BASE;
            chg_nxt          = 1'b0;
            retry_nxt        = 2'd0;
            speed_change_nxt = 1'b0;
            state_nxt        = SEQ_IDLE;
          end
        end
      end

      SEQ_SETTLE: begin
        // Lock timer keeps running so repeated glitches still end in a timeout
        lock_inc = 1'b1;
        if (!pll_locked) begin
          state_nxt = SEQ_LOCK;
        end else if (settle_cnt >= SETTLE_LAST) begin
          done_nxt         = 1'b1;
          chg_nxt          = is_operational_speed(cfg_speed);
          retry_nxt        = 2'd0;
          speed_change_nxt = 1'b1;
          state_nxt        = SEQ_DONE;
        end else begin
          settle_inc = 1'b1;
        end
      end

      SEQ_DONE: begin
        state_nxt = SEQ_WAIT_LOW;
      end

      SEQ_WAIT_LOW: begin
        if (!pll_reconfig) begin
          state_nxt = SEQ_IDLE;
        end
      end

      default: begin
        state_nxt = SEQ_IDLE;
      end
    endcase
  end

  // State and output registers; PLL reset is asserted while the block is in reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= SEQ_IDLE;
      cfg_req                <= 1'b0;
      cfg_speed              <= LINK_SPEED_BASE;
      pll_areset             <= 1'b1;
      pll_configuration_done <= 1'b0;
      change_freq_st         <= 1'b0;
      pll_error              <= 1'b0;
      retry_cnt              <= 2'd0;
      speed_change           <= 1'b0;
    end else begin
      state                  <= state_nxt;
      cfg_req                <= cfg_req_nxt;
      cfg_speed              <= target_nxt;
      pll_areset             <= areset_nxt;
      pll_configuration_done <= done_nxt;
      change_freq_st         <= chg_nxt;
      pll_error              <= err_nxt;
      retry_cnt              <= retry_nxt;
      speed_change           <= speed_change_nxt;
    end
  end

endmodule

// File: tb/tb_mgmt_phy_pll_sequencer.sv
// tb/tb_mgmt_phy_pll_sequencer.sv - self-checking bench for mgmt_phy_pll_sequencer
module tb_mgmt_phy_pll_sequencer;
  import ltpi_pkg::*;

  localparam int RH     = 16;
  localparam int TO     = 400;
  localparam int SC     = 64;
  localparam int BUDGET = 2000;

  logic           clk;
  logic           reset_n;
  logic           pll_reconfig;
  link_speed_t    operational_speed;
  logic           pll_locked;
  logic           cfg_ack;
  logic           cfg_req;
  link_speed_t    cfg_speed;
  logic           pll_areset;
  logic           pll_configuration_done;
  logic           change_freq_st;
  logic           pll_error;
  logic [1:0]     retry_cnt;
  pll_seq_state_t seq_state;

  int total;
  int bad;

  // Reference model: what the PLL currently runs at and whether the last config succeeded
  bit m_chg;
  bit m_ok;
  bit m_err;

  mgmt_phy_pll_sequencer #(
    .RESET_HOLD_CYC   (RH),
    .LOCK_TIMEOUT_CYC (TO),
    .SETTLE_CYC       (SC),
    .MAX_RETRY        (3)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .pll_reconfig           (pll_reconfig),
    .operational_speed      (operational_speed),
    .pll_locked             (pll_locked),
    .cfg_ack                (cfg_ack),
    .cfg_req                (cfg_req),
    .cfg_speed              (cfg_speed),
    .pll_areset             (pll_areset),
    .pll_configuration_done (pll_configuration_done),
    .change_freq_st         (change_freq_st),
    .pll_error              (pll_error),
    .retry_cnt              (retry_cnt),
    .seq_state              (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_cfg_req"},   int'(cfg_req), 0);
    chk({pfx, "_cfg_speed"}, int'(cfg_speed), int'(LINK_SPEED_BASE));
    chk({pfx, "_areset"},    int'(pll_areset), 1);
    chk({pfx, "_done"},      int'(pll_configuration_done), 0);
    chk({pfx, "_chg"},       int'(change_freq_st), 0);
    chk({pfx, "_err"},       int'(pll_error), 0);
    chk({pfx, "_retry"},     int'(retry_cnt), 0);
    chk({pfx, "_state"},     int'(seq_state), int'(SEQ_IDLE));
  endtask

  // One request with an acking reconfig IP and a PLL that locks lat cycles after reset release,
  // optionally dropping lock for one cycle after gl locked cycles
  task automatic run_req(input link_speed_t op, input int d, input int lat, input int gl,
                         input bit drop_mid);
    link_speed_t tgt;
    int k, cfg_seen, since_rel, areset_hi, attempts, exp_done;
    bit armed, rel_checked, done_seen;
    tgt      = (!m_chg && m_ok) ? op : LINK_SPEED_BASE;
    exp_done = RH + d + 1 + lat + SC + 1 + ((gl > 0) ? gl + 1 : 0);
    k = 0; cfg_seen = 0; since_rel = 0; areset_hi = 0; attempts = 0;
    armed = 0; rel_checked = 0; done_seen = 0;
    operational_speed = op;
    pll_reconfig      = 1'b1;
    pll_locked        = 1'b0;
    cfg_ack           = 1'b0;
    while (!done_seen && k < BUDGET) begin
      @(negedge clk);
      k++;
      if (k == 3) operational_speed = link_speed_t'((int'(op) + 1) % 9);
      if (drop_mid && k == 8) pll_reconfig = 1'b0;
      if (cfg_req) begin
        if (cfg_seen == 0) begin
          attempts++;
          chk("cfg_speed", int'(cfg_speed), int'(tgt));
        end
        cfg_seen++;
        cfg_ack = (cfg_seen == d + 1);
      end else begin
        cfg_seen = 0;
        cfg_ack  = 1'b0;
      end
      if (!rel_checked) begin
        if (pll_areset) areset_hi++;
        else begin
          chk("areset_width", areset_hi, RH + d + 1);
          rel_checked = 1;
        end
      end
      if (pll_areset) begin
        armed     = 1;
        since_rel = 0;
      end else if (armed) begin
        since_rel++;
      end
      pll_locked = armed && (since_rel >= lat) && !(gl > 0 && since_rel == lat + gl);
      if (pll_configuration_done) begin
        done_seen = 1;
        chk("done_cycle", k, exp_done);
        chk("chg_at_done", int'(change_freq_st), int'(tgt != LINK_SPEED_BASE));
        chk("retry_at_done", int'(retry_cnt), 0);
        chk("attempts", attempts, 1);
        chk("err_at_done", int'(pll_error), int'(m_err));
      end
    end
    chk("done_reached", int'(done_seen), 1);
    @(negedge clk);
    chk("done_width", int'(pll_configuration_done), 0);
    chk("wait_low1", int'(seq_state), int'(SEQ_WAIT_LOW));
    if (!drop_mid) begin
      @(negedge clk);
      chk("wait_low2", int'(seq_state), int'(SEQ_WAIT_LOW));
      chk("no_retrigger", int'(pll_areset), 0);
      pll_reconfig = 1'b0;
    end
    @(negedge clk);
    chk("back_idle", int'(seq_state), int'(SEQ_IDLE));
    chk("chg_hold", int'(change_freq_st), int'(tgt != LINK_SPEED_BASE));
    m_ok  = 1;
    m_chg = (tgt != LINK_SPEED_BASE);
  endtask

  // PLL never locks: three full attempts, then error with the request still pending
  task automatic run_fail(input link_speed_t op, input int d);
    link_speed_t tgt;
    int k, cfg_seen, attempts, period;
    tgt    = (!m_chg && m_ok) ? op : LINK_SPEED_BASE;
    period = RH + d + 1 + TO;
    k = 0; cfg_seen = 0; attempts = 0;
    operational_speed = op;
    pll_reconfig      = 1'b1;
    pll_locked        = 1'b0;
    cfg_ack           = 1'b0;
    while (k < 3 * period + 1) begin
      @(negedge clk);
      k++;
      if (cfg_req) begin
        if (cfg_seen == 0) begin
          attempts++;
          chk("retry_speed", int'(cfg_speed), int'(tgt));
        end
        cfg_seen++;
        cfg_ack = (cfg_seen == d + 1);
      end else begin
        cfg_seen = 0;
        cfg_ack  = 1'b0;
      end
      if (k == period)         chk("retry_cnt0", int'(retry_cnt), 0);
      if (k == period + 1)     chk("retry_cnt1", int'(retry_cnt), 1);
      if (k == 2 * period + 1) chk("retry_cnt2", int'(retry_cnt), 2);
      if (k == 3 * period)     chk("err_not_early", int'(pll_error), 0);
    end
    chk("fail_attempts", attempts, 3);
    chk("fail_err", int'(pll_error), 1);
    chk("fail_retry", int'(retry_cnt), 0);
    chk("fail_chg", int'(change_freq_st), 0);
    chk("fail_state", int'(seq_state), int'(SEQ_IDLE));
    chk("fail_no_done", int'(pll_configuration_done), 0);
    m_err = 1; m_chg = 0; m_ok = 0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    total = 0; bad = 0;
    m_chg = 0; m_ok = 0; m_err = 0;
    reset_n           = 1'b0;
    pll_reconfig      = 1'b0;
    operational_speed = LINK_SPEED_1X;
    pll_locked        = 1'b0;
    cfg_ack           = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_areset", int'(pll_areset), 0);
    chk("idle_state", int'(seq_state), int'(SEQ_IDLE));

    run_req(LINK_SPEED_8X, 3, 100, 0, 0);
    run_req(LINK_SPEED_8X, 2, 30, 0, 0);
    run_req(LINK_SPEED_4X, 1, 20, 0, 0);
    run_req(LINK_SPEED_8X, 0, 50, 41, 0);
    run_req(LINK_SPEED_2X, 4, 10, 0, 1);

    for (int i = 0; i < 6; i++) begin
      run_req(link_speed_t'($urandom_range(0, 8)), int'($urandom_range(0, 5)),
              int'($urandom_range(1, 150)),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, SC)) : 0,
              1'($urandom_range(0, 1)));
    end

    if (m_chg) run_req(LINK_SPEED_1X, 1, 10, 0, 0);
    run_fail(LINK_SPEED_16X, 2);

    k = 0;
    while (!cfg_req && k < 4 * RH) begin
      @(negedge clk);
      k++;
    end
    chk("att4_latency", k, RH + 1);
    chk("att4_speed", int'(cfg_speed), int'(LINK_SPEED_BASE));
    chk("err_sticky", int'(pll_error), 1);
    cfg_ack = 1'b1;
    @(negedge clk);
    cfg_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("att4_lock", int'(seq_state), int'(SEQ_LOCK));
    chk("att4_areset", int'(pll_areset), 0);
    reset_n      = 1'b0;
    pll_reconfig = 1'b0;
    #1;
    chk_reset_vals("mid");
    m_chg = 0; m_ok = 0; m_err = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      run_req(link_speed_t'($urandom_range(1, 8)), int'($urandom_range(0, 5)),
              int'($urandom_range(1, 150)), 0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
